// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg: mode and SR conflict policy constants for the flip-flop bank
package ff_bank_pkg;
    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_SR = 2'b10;
    localparam logic [1:0] MODE_JK = 2'b11;
    localparam int SR_SET_DOM = 0;
    localparam int SR_RST_DOM = 1;
    localparam int SR_HOLD    = 2;
endpackage

// File: rtl/ff_cell.sv
// ff_cell: one-bit D/T/SR/JK next-state function with SR conflict detection
import ff_bank_pkg::*;
module ff_cell #(
    parameter int POLICY = SR_SET_DOM
) (
    input  logic       q,
    input  logic       a,
    input  logic       b,
    input  logic [1:0] mode,
    output logic       q_next,
    output logic       conflict
);
    logic sr_both;
    always_comb begin
        conflict = (mode == MODE_SR) && a && b;
        sr_both  = POLICY == SR_SET_DOM ? 1'b1 : POLICY == SR_RST_DOM ? 1'b0 : q;
        q_next   = mode == MODE_D ? a :
                   mode == MODE_T ? q ^ a :
                   (a && b) ? (mode == MODE_JK ? ~q : sr_both) :
                   a ? 1'b1 : b ? 1'b0 : q;
    end
endmodule

// File: rtl/ff_bank.sv
// ff_bank: WIDTH flip-flop channels updated on the falling edge with sticky SR conflict tracking
import ff_bank_pkg::*;
module ff_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8,
    parameter int SR_POLICY = SR_SET_DOM,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt
);
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] hit;
    logic             event_hit;
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        ff_cell #(.POLICY(SR_POLICY)) u_cell (
            .q(q[g]), .a(a[g]), .b(b[g]), .mode(mode),
            .q_next(q_next[g]), .conflict(hit[g])
        );
    end
    always_comb event_hit = en && (|hit);
    // an event in the same cycle as clr_err restarts history from this cycle
    always_ff @(negedge clk) begin
        if (!reset) begin
            q            <= RESET_VAL;
            qn           <= ~RESET_VAL;
            conflict     <= '0;
            conflict_cnt <= '0;
        end else begin
            if (en) begin
                q  <= q_next;
                qn <= ~q_next;
            end
            if (event_hit) begin
                conflict     <= clr_err ? hit : conflict | hit;
                conflict_cnt <= clr_err ? CNT_W'(1) : (&conflict_cnt) ? conflict_cnt : conflict_cnt + CNT_W'(1);
            end else if (clr_err) begin
                conflict     <= '0;
                conflict_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ff_bank.sv
// tb_ff_bank: directed vectors with a scoreboard queue checked by a falling-edge monitor
module tb_ff_bank;
    typedef struct packed {
        logic [7:0] id;
        logic [7:0] q0;
        logic [7:0] q1;
        logic [7:0] q2;
        logic [7:0] c;
        logic [1:0] n;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic clr_err = 1'b0;
    logic [7:0] q[3];
    logic [7:0] qn[3];
    logic [7:0] c[3];
    logic [1:0] n[3];
    exp_t sb[$];
    int passed = 0;
    int total = 0;
    int sid = 0;
    always #5 clk = ~clk;
    ff_bank #(.WIDTH(8), .CNT_W(2), .SR_POLICY(0)) u0 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(q[0]), .qn(qn[0]), .conflict(c[0]), .conflict_cnt(n[0]));
    ff_bank #(.WIDTH(8), .CNT_W(2), .SR_POLICY(1)) u1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(q[1]), .qn(qn[1]), .conflict(c[1]), .conflict_cnt(n[1]));
    ff_bank #(.WIDTH(8), .CNT_W(2), .SR_POLICY(2)) u2 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(q[2]), .qn(qn[2]), .conflict(c[2]), .conflict_cnt(n[2]));
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask
    task automatic step(input logic rs, input logic e, input logic [1:0] md, input logic [7:0] av,
                        input logic [7:0] bv, input logic clr, input logic [7:0] e0,
                        input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] ec,
                        input logic [1:0] encnt);
        exp_t x;
        @(posedge clk);
        reset = rs; en = e; mode = md; a = av; b = bv; clr_err = clr;
        sid++;
        x.id = 8'(sid); x.q0 = e0; x.q1 = e1; x.q2 = e2; x.c = ec; x.n = encnt;
        sb.push_back(x);
    endtask
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() != 0) begin
                exp_t x;
                logic [7:0] eq[3];
                x = sb.pop_front();
                eq[0] = x.q0; eq[1] = x.q1; eq[2] = x.q2;
                for (int p = 0; p < 3; p++) begin
                    chk($sformatf("step%0d p%0d q", x.id, p), q[p], eq[p]);
                    chk($sformatf("step%0d p%0d qn", x.id, p), qn[p], ~eq[p]);
                    chk($sformatf("step%0d p%0d conflict", x.id, p), c[p], x.c);
                    chk($sformatf("step%0d p%0d cnt", x.id, p), {6'b0, n[p]}, {6'b0, x.n});
                end
            end
        end
    end
    initial begin
        //   rst en mode   a      b      clr  q(p0)  q(p1)  q(p2)  conf   cnt
        step(0, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
        step(0, 1, 2'b00, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
        step(1, 1, 2'b00, 8'hA5, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'h00, 2'd0);
        step(1, 1, 2'b01, 8'h0F, 8'h00, 0, 8'hAA, 8'hAA, 8'hAA, 8'h00, 2'd0);
        step(1, 0, 2'b01, 8'hFF, 8'h00, 0, 8'hAA, 8'hAA, 8'hAA, 8'h00, 2'd0);
        step(1, 0, 2'b01, 8'hFF, 8'h00, 0, 8'hAA, 8'hAA, 8'hAA, 8'h00, 2'd0);
        step(1, 0, 2'b01, 8'hFF, 8'h00, 0, 8'hAA, 8'hAA, 8'hAA, 8'h00, 2'd0);
        step(1, 1, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
        step(1, 1, 2'b10, 8'h01, 8'h01, 0, 8'h01, 8'h00, 8'h00, 8'h01, 2'd1);
        step(1, 1, 2'b00, 8'hF0, 8'h00, 0, 8'hF0, 8'hF0, 8'hF0, 8'h01, 2'd1);
        step(1, 1, 2'b11, 8'hFF, 8'hFF, 0, 8'h0F, 8'h0F, 8'h0F, 8'h01, 2'd1);
        step(1, 1, 2'b11, 8'h01, 8'h80, 0, 8'h0F, 8'h0F, 8'h0F, 8'h01, 2'd1);
        step(1, 1, 2'b11, 8'hF0, 8'h0F, 0, 8'hF0, 8'hF0, 8'hF0, 8'h01, 2'd1);
        step(1, 1, 2'b10, 8'h00, 8'h00, 0, 8'hF0, 8'hF0, 8'hF0, 8'h01, 2'd1);
        step(1, 1, 2'b10, 8'h0F, 8'hF0, 0, 8'h0F, 8'h0F, 8'h0F, 8'h01, 2'd1);
        step(1, 1, 2'b10, 8'h01, 8'h01, 0, 8'h0F, 8'h0E, 8'h0F, 8'h01, 2'd2);
        step(1, 1, 2'b10, 8'h01, 8'h01, 0, 8'h0F, 8'h0E, 8'h0F, 8'h01, 2'd3);
        step(1, 1, 2'b10, 8'h01, 8'h01, 0, 8'h0F, 8'h0E, 8'h0F, 8'h01, 2'd3);
        step(1, 1, 2'b10, 8'h01, 8'h01, 0, 8'h0F, 8'h0E, 8'h0F, 8'h01, 2'd3);
        step(1, 1, 2'b10, 8'h01, 8'h01, 0, 8'h0F, 8'h0E, 8'h0F, 8'h01, 2'd3);
        step(1, 0, 2'b10, 8'hFF, 8'hFF, 0, 8'h0F, 8'h0E, 8'h0F, 8'h01, 2'd3);
        step(1, 0, 2'b10, 8'h00, 8'h00, 1, 8'h0F, 8'h0E, 8'h0F, 8'h00, 2'd0);
        step(1, 1, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
        step(1, 1, 2'b10, 8'h80, 8'h80, 1, 8'h80, 8'h00, 8'h00, 8'h80, 2'd1);
        step(1, 1, 2'b10, 8'h03, 8'h03, 0, 8'h83, 8'h00, 8'h00, 8'h83, 2'd2);
        step(0, 1, 2'b10, 8'hFF, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
        step(1, 1, 2'b00, 8'h3C, 8'h00, 0, 8'h3C, 8'h3C, 8'h3C, 8'h00, 2'd0);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
